// File: rtl/decoder_rr_arbiter.sv
// 8-way round-robin arbiter whose registered grant index drives the A/B/C
// selects of a 3-to-8 decoder; owners are separated by one dead cycle.
//
// state | meaning
// IDLE  | no owner, arbitrating every cycle from ptr
// GRANT | grant_id owns the resource, hold counter running
// GAP   | single dead cycle after a release, arbitrating for the next owner
module decoder_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] req,
  output logic       sel_A,
  output logic       sel_B,
  output logic       sel_C,
  output logic [7:0] grant,
  output logic       grant_vld,
  output logic [2:0] grant_id,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [2:0]       grant_id_q, grant_id_d;
  logic             grant_vld_q, grant_vld_d;
  logic             timeout_q, timeout_d;

  logic             win_found;
  logic [2:0]       win_idx;
  logic [2:0]       scan_idx;
  logic             others_pend;

  // First set request scanning upward from ptr with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    scan_idx  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      scan_idx = ptr_q + 3'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  assign others_pend = |(req & ~(8'h01 << grant_id_q));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_cnt_d  = hold_cnt_q;
    grant_id_d  = grant_id_q;
    grant_vld_d = grant_vld_q;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE, GAP: begin
        if (win_found) begin
          state_d     = GRANT;
          grant_id_d  = win_idx;
          grant_vld_d = 1'b1;
          hold_cnt_d  = '0;
          ptr_d       = win_idx + 3'd1;
        end else begin
          state_d     = IDLE;
          grant_vld_d = 1'b0;
        end
      end
      GRANT: begin
        // A dropping owner wins over a coincident timeout: plain release.
        if (!req[grant_id_q]) begin
          state_d     = GAP;
          grant_vld_d = 1'b0;
        end else if (hold_cnt_q == HOLD_LAST && others_pend) begin
          state_d     = GAP;
          grant_vld_d = 1'b0;
          timeout_d   = 1'b1;
        end else if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        grant_vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      hold_cnt_q  <= '0;
      grant_id_q  <= 3'd0;
      grant_vld_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      grant_id_q  <= grant_id_d;
      grant_vld_q <= grant_vld_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    grant = 8'h00;
    if (grant_vld_q) grant = 8'h01 << grant_id_q;
  end

  assign sel_A     = grant_id_q[2];
  assign sel_B     = grant_id_q[1];
  assign sel_C     = grant_id_q[0];
  assign grant_vld = grant_vld_q;
  assign grant_id  = grant_id_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Bench for decoder_rr_arbiter: vector table, directed corner sequences and
// randomized requests against an owner/ptr reference model.
module tb_decoder_rr_arbiter;
  localparam int MH = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] req;
  logic       sel_A, sel_B, sel_C;
  logic [7:0] grant;
  logic       grant_vld;
  logic [2:0] grant_id;
  logic       timeout;

  decoder_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(3)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .req      (req),
    .sel_A    (sel_A),
    .sel_B    (sel_B),
    .sel_C    (sel_C),
    .grant    (grant),
    .grant_vld(grant_vld),
    .grant_id (grant_id),
    .timeout  (timeout)
  );

  always #5 sys_clk = ~sys_clk;

  int tests  = 0;
  int failed = 0;

  // Reference model: who owns, who owned last, how long, where the scan starts.
  int m_owner, m_last, m_ptr, m_held;
  bit m_to;

  function automatic int first_from(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_to = 0;
  endtask

  task automatic model_update(input logic [7:0] r);
    int w;
    m_to = 0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) m_owner = -1;
      else if (m_held >= MH && (r & ~(8'h01 << m_owner)) != 8'h00) begin
        m_owner = -1;
        m_to = 1;
      end else m_held++;
    end else begin
      w = first_from(r, m_ptr);
      if (w >= 0) begin
        m_owner = w; m_last = w; m_held = 1; m_ptr = (w + 1) % 8;
      end
    end
  endtask

  task automatic check_model(input string name);
    logic [7:0] eg;
    logic       ev;
    eg = 8'h00;
    ev = (m_owner >= 0);
    if (ev) eg = 8'h01 << m_owner;
    tests++;
    if (grant !== eg || grant_vld !== ev || grant_id !== 3'(m_last) ||
        {sel_A, sel_B, sel_C} !== 3'(m_last) || timeout !== m_to) begin
      failed++;
      $display("FAIL %s: got vld=%b id=%0d sel=%b%b%b grant=%h to=%b, want vld=%b id=%0d grant=%h to=%b",
               name, grant_vld, grant_id, sel_A, sel_B, sel_C, grant, timeout, ev, m_last, eg, m_to);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] r, input string name);
    req = r;
    @(posedge sys_clk);
    model_update(r);
    @(negedge sys_clk);
    check_model(name);
  endtask

  // Async reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset(input string name);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    req = 8'h00;
    #1;
    model_reset();
    check_model(name);
    check_val({name, "_grant"}, int'(grant), 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] r;
    logic       vld;
    logic [2:0] id;
    logic [7:0] g;
    logic       to;
  } vec_t;

  vec_t       tbl[15];
  int         order_q[$];
  int         exp_order[9];
  int         to_cnt, own_cnt;
  logic       prev_vld;
  logic [7:0] cur;

  initial begin
    tbl[0]  = '{8'h01, 1'b1, 3'd0, 8'h01, 1'b0};
    tbl[1]  = '{8'h01, 1'b1, 3'd0, 8'h01, 1'b0};
    tbl[2]  = '{8'h01, 1'b1, 3'd0, 8'h01, 1'b0};
    tbl[3]  = '{8'h01, 1'b1, 3'd0, 8'h01, 1'b0};
    tbl[4]  = '{8'h01, 1'b1, 3'd0, 8'h01, 1'b0};
    tbl[5]  = '{8'h00, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[6]  = '{8'h00, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[7]  = '{8'h20, 1'b1, 3'd5, 8'h20, 1'b0};
    tbl[8]  = '{8'h00, 1'b0, 3'd5, 8'h00, 1'b0};
    tbl[9]  = '{8'h41, 1'b1, 3'd6, 8'h40, 1'b0};
    tbl[10] = '{8'h41, 1'b1, 3'd6, 8'h40, 1'b0};
    tbl[11] = '{8'h01, 1'b0, 3'd6, 8'h00, 1'b0};
    tbl[12] = '{8'h01, 1'b1, 3'd0, 8'h01, 1'b0};
    tbl[13] = '{8'h00, 1'b0, 3'd0, 8'h00, 1'b0};
    tbl[14] = '{8'h00, 1'b0, 3'd0, 8'h00, 1'b0};
    for (int i = 0; i < 9; i++) exp_order[i] = i % 8;

    sys_rst_n = 1'b0;
    req = 8'h00;
    model_reset();
    repeat (2) @(negedge sys_clk);
    check_model("reset_state");
    sys_rst_n = 1'b1;

    for (int i = 0; i < 10; i++) step(8'h00, "idle_no_req");

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].r, "table_model");
      tests++;
      if (grant_vld !== tbl[i].vld || grant_id !== tbl[i].id ||
          grant !== tbl[i].g || timeout !== tbl[i].to ||
          {sel_A, sel_B, sel_C} !== tbl[i].id) begin
        failed++;
        $display("FAIL table[%0d]: got vld=%b id=%0d grant=%h to=%b, want vld=%b id=%0d grant=%h to=%b",
                 i, grant_vld, grant_id, grant, timeout, tbl[i].vld, tbl[i].id, tbl[i].g, tbl[i].to);
      end
    end

    // All requesting: strict rotation, MH cycles each, pulse at each handover.
    do_reset("reset_before_ff");
    to_cnt = 0;
    prev_vld = 1'b0;
    for (int i = 0; i < 45; i++) begin
      step(8'hFF, "all_req");
      if (timeout) to_cnt++;
      if (grant_vld && !prev_vld) order_q.push_back(int'(grant_id));
      prev_vld = grant_vld;
    end
    check_val("ff_timeouts", to_cnt, 9);
    check_val("ff_grant_count", order_q.size(), 9);
    for (int i = 0; i < 9 && i < order_q.size(); i++)
      check_val("ff_order", order_q[i], exp_order[i]);

    // Sole requester holds past saturation; late competitor forces release.
    do_reset("reset_before_sole");
    to_cnt = 0;
    own_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(8'h08, "sole_hold");
      if (timeout) to_cnt++;
      if (grant == 8'h08) own_cnt++;
    end
    check_val("sole_no_timeout", to_cnt, 0);
    check_val("sole_unbroken", own_cnt, 40);
    step(8'h28, "late_competitor_to");
    check_val("late_timeout_pulse", int'(timeout), 1);
    check_val("late_gap_vld", int'(grant_vld), 0);
    step(8'h28, "late_competitor_grant");
    check_val("late_new_grant", int'(grant), 32'h20);
    step(8'h28, "late_competitor_hold");
    check_val("late_pulse_one_cycle", int'(timeout), 0);

    // Reset mid-grant clears outputs at once and restarts the scan at 0.
    do_reset("reset_before_mid");
    step(8'h20, "mid_setup");
    step(8'h20, "mid_setup_hold");
    do_reset("reset_mid_grant");
    step(8'h81, "after_reset_scan");
    check_val("after_reset_ptr0", int'(grant), 32'h01);

    // Same-cycle release and timeout condition: release wins, no pulse.
    do_reset("reset_before_coinc");
    for (int i = 0; i < MH; i++) step(8'h01, "coinc_hold");
    step(8'h02, "coinc_release");
    check_val("coinc_no_timeout", int'(timeout), 0);

    do_reset("reset_before_rand");
    cur = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) cur = 8'($urandom);
      else if ($urandom_range(15) == 0) cur = 8'h01 << $urandom_range(7);
      step(cur, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
